// File: rtl/shift_reg_pkg.sv
// Shared constants for the serial delay-line family: default depth, legal depth range
// and the value every stage clears to.
`timescale 1ns/100ps
package shift_reg_pkg;

    localparam int   SHIFT_DEPTH_DEFAULT = 4;
    localparam int   SHIFT_DEPTH_MIN     = 1;
    localparam int   SHIFT_DEPTH_MAX     = 64;
    localparam logic SHIFT_RESET_VAL     = 1'b0;

endpackage : shift_reg_pkg

// File: rtl/shift_stage.sv
// One link of the delay line: a D flop that clears asynchronously to RESET_VAL
// whenever resetn is low.
`timescale 1ns/100ps
module shift_stage
    import shift_reg_pkg::*;
#(
    parameter logic RESET_VAL = SHIFT_RESET_VAL
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q <= RESET_VAL;
        end else begin
            q <= d;
        end
    end

endmodule : shift_stage

// File: rtl/shift_reg4.sv
// Serial-in, serial-out delay line: DEPTH chained flops, so a bit captured on one edge
// reaches out right after the (DEPTH-1)th following edge.
`timescale 1ns/100ps
module shift_reg4
    import shift_reg_pkg::*;
#(
    parameter int   DEPTH     = SHIFT_DEPTH_DEFAULT,
    parameter logic RESET_VAL = SHIFT_RESET_VAL
) (
    input  logic clk,
    input  logic resetn,
    input  logic in,
    output logic out
);

    if (DEPTH < SHIFT_DEPTH_MIN || DEPTH > SHIFT_DEPTH_MAX) begin : g_depth_check
        $fatal(1, "shift_reg4: DEPTH=%0d outside legal range %0d..%0d",
               DEPTH, SHIFT_DEPTH_MIN, SHIFT_DEPTH_MAX);
    end

    logic [DEPTH-1:0] stage;

    // Stage 0 takes the serial input; every later stage takes its predecessor.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic d;

        if (i == 0) begin : g_head
            assign d = in;
        end else begin : g_tail
            assign d = stage[i-1];
        end

        shift_stage #(
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .clk    (clk),
            .resetn (resetn),
            .d      (d),
            .q      (stage[i])
        );
    end

    assign out = stage[DEPTH-1];

endmodule : shift_reg4

// File: tb/tb_shift_reg4.sv
// Scoreboard bench: three delay lines (DEPTH 4, 1, 8) share one input stream; each
// captured bit is queued and popped when the matching output is due.
`timescale 1ns/100ps
module tb_shift_reg4;

    logic clk;
    logic resetn;
    logic din;
    logic out4;
    logic out1;
    logic out8;

    int checkCount;
    int errorCount;

    logic q4[$];
    logic q1[$];
    logic q8[$];

    shift_reg4 #(.DEPTH(4), .RESET_VAL(1'b0)) dut4 (
        .clk    (clk),
        .resetn (resetn),
        .in     (din),
        .out    (out4)
    );

    shift_reg4 #(.DEPTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk    (clk),
        .resetn (resetn),
        .in     (din),
        .out    (out1)
    );

    shift_reg4 #(.DEPTH(8), .RESET_VAL(1'b0)) dut8 (
        .clk    (clk),
        .resetn (resetn),
        .in     (din),
        .out    (out8)
    );

    // Rising edges at t=1,3,5,...; stimulus and sampling both happen on falling edges.
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at t=%0t: got %b, expected %b", tag, $time, actual, expected);
        end
    endtask

    // Just after reset every stage holds 0, so the first DEPTH-1 outputs are 0.
    task automatic resetScoreboard();
        q4.delete();
        q1.delete();
        q8.delete();
        repeat (3) q4.push_back(1'b0);
        repeat (7) q8.push_back(1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_d4"}, out4, 1'b0);
        checkOutput({tag, "_d1"}, out1, 1'b0);
        checkOutput({tag, "_d8"}, out8, 1'b0);
    endtask

    // Called on a falling edge: drive one bit, let the rising edge capture it,
    // then compare each output against the bit that is due at the next falling edge.
    task automatic applyStimulus(input logic b);
        din = b;
        q4.push_back(b);
        q1.push_back(b);
        q8.push_back(b);
        @(posedge clk);
        @(negedge clk);
        checkOutput("d4", out4, q4.pop_front());
        checkOutput("d1", out1, q1.pop_front());
        checkOutput("d8", out8, q8.pop_front());
    endtask

    // Assert reset between edges, hold it across one rising edge, release on a falling edge.
    task automatic pulseReset(input string tag);
        resetn = 1'b0;
        #0.2;
        checkAllZero({tag, "_assert"});
        @(negedge clk);
        checkAllZero({tag, "_held"});
        resetn = 1'b1;
        resetScoreboard();
    endtask

    initial begin
        logic [7:0] walk;
        checkCount = 0;
        errorCount = 0;
        resetn     = 1'b1;
        din        = 1'b1;

        $display("[TB] power-up and async clear");
        #2;
        pulseReset("por");

        $display("[TB] single-stream latency");
        applyStimulus(1'b1);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        // After edge t=9 (third sample) DEPTH=4 still shows the reset value.
        checkOutput("lat_pre_t10", out4, 1'b0);
        applyStimulus(1'b1);
        checkOutput("lat_t12", out4, 1'b1);
        applyStimulus(1'b1);
        checkOutput("lat_t14", out4, 1'b0);
        applyStimulus(1'b1);
        checkOutput("lat_t16", out4, 1'b1);
        repeat (6) applyStimulus(1'b1);

        $display("[TB] walking pattern");
        walk = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) applyStimulus(walk[i]);
        repeat (8) applyStimulus(1'b0);

        $display("[TB] reset mid-stream");
        repeat (8) applyStimulus(1'b1);
        checkOutput("full_d8", out8, 1'b1);
        pulseReset("mid");
        repeat (10) applyStimulus(1'b0);

        $display("[TB] constant input");
        repeat (10) applyStimulus(1'b1);
        checkOutput("const_hi", out4, 1'b1);
        repeat (10) applyStimulus(1'b0);
        checkOutput("const_lo", out4, 1'b0);

        $display("[TB] random stream");
        for (int i = 0; i < 40; i++) applyStimulus(1'($urandom_range(0, 1)));
        pulseReset("end");
        repeat (4) applyStimulus(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule : tb_shift_reg4
